// File: rtl/synth_pkg.sv
// synth_pkg: voice allocator FSM and duty encodings plus top-octave period table
package synth_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_ALLOC} state_t;
  typedef enum logic [1:0] {DUTY_50, DUTY_25, DUTY_12, DUTY_75} duty_t;
  function automatic logic [12:0] base_period(input logic [3:0] s);
    case (s)
      4'd0:    return 13'd5972;
      4'd1:    return 13'd5637;
      4'd2:    return 13'd5321;
      4'd3:    return 13'd5022;
      4'd4:    return 13'd4740;
      4'd5:    return 13'd4474;
      4'd6:    return 13'd4223;
      4'd7:    return 13'd3986;
      4'd8:    return 13'd3762;
      4'd9:    return 13'd3551;
      4'd10:   return 13'd3352;
      4'd11:   return 13'd3164;
      default: return 13'd0;
    endcase
  endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note event handshake (ev_*, duty_mode) and per-voice control outputs (voice_*)
interface voice_allocator_if #(parameter int NUM_VOICES = 4, parameter int PW = 32);
  logic ev_valid, ev_ready, ev_on;
  logic [6:0] ev_note;
  logic [1:0] duty_mode;
  logic [NUM_VOICES*PW-1:0] voice_period, voice_duty;
  logic [NUM_VOICES-1:0] voice_restart, voice_active;
  logic [NUM_VOICES*7-1:0] voice_note;
  modport master (output ev_valid, ev_on, ev_note, duty_mode,
                  input ev_ready, voice_period, voice_duty, voice_restart, voice_active, voice_note);
  modport slave (input ev_valid, ev_on, ev_note, duty_mode,
                 output ev_ready, voice_period, voice_duty, voice_restart, voice_active, voice_note);
endinterface

// File: rtl/note_period_rom.sv
// note_period_rom: note_i (MIDI 0..127) -> period_o in clk cycles, registered, 1-cycle latency
module note_period_rom import synth_pkg::*; #(parameter int PW = 32) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    note_i,
  output logic [PW-1:0] period_o
);
  logic [3:0] oct, semi;
  logic [PW-1:0] period_q;
  assign oct = 4'(note_i / 7'd12);
  assign semi = 4'(note_i % 7'd12);
  assign period_o = period_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) period_q <= '0;
    else period_q <= PW'(base_period(semi)) << (4'd10 - oct);
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events from bus (slave) to NUM_VOICES square voices, stealing the oldest; clk, async reset
module voice_allocator import synth_pkg::*; #(parameter int NUM_VOICES = 4, parameter int PW = 32) (
  input logic clk,
  input logic reset,
  voice_allocator_if.slave bus
);
  localparam int AW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam logic [2:0] AGE_MAX = 3'(NUM_VOICES - 1);
  state_t state_q;
  logic on_q;
  logic [6:0] ev_note_q;
  logic [PW-1:0] period, duty_on;
  logic [NUM_VOICES-1:0][PW-1:0] period_q, duty_q;
  logic [NUM_VOICES-1:0][6:0] note_q;
  logic [NUM_VOICES-1:0][2:0] age_q;
  logic [NUM_VOICES-1:0] active_q, restart_q;
  logic hit, free;
  logic [AW-1:0] hit_idx, free_idx, old_idx, sel;
  note_period_rom #(.PW(PW)) u_rom (.clk(clk), .reset(reset), .note_i(ev_note_q), .period_o(period));
  assign bus.ev_ready = (state_q == S_IDLE) && !reset;
  assign bus.voice_period = period_q;
  assign bus.voice_duty = duty_q;
  assign bus.voice_note = note_q;
  assign bus.voice_active = active_q;
  assign bus.voice_restart = restart_q;
  // descending scans leave the lowest matching index; ages compare strictly so ties keep the lower index
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    old_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && note_q[i] == ev_note_q) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
      if (!active_q[i]) begin
        free = 1'b1;
        free_idx = AW'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++)
      if (age_q[i] > age_q[old_idx]) old_idx = AW'(i);
    sel = hit ? hit_idx : free ? free_idx : old_idx;
    duty_on = duty_t'(bus.duty_mode) == DUTY_25 ? period >> 2 :
              duty_t'(bus.duty_mode) == DUTY_12 ? period >> 3 :
              duty_t'(bus.duty_mode) == DUTY_75 ? period - (period >> 2) : period >> 1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      on_q <= 1'b0;
      ev_note_q <= '0;
      period_q <= '0;
      duty_q <= '0;
      note_q <= '0;
      age_q <= '0;
      active_q <= '0;
      restart_q <= '0;
    end else begin
      restart_q <= '0;
      if (state_q == S_IDLE && bus.ev_valid && bus.ev_ready) begin
        on_q <= bus.ev_on;
        ev_note_q <= bus.ev_note;
        state_q <= S_LOOKUP;
      end else if (state_q == S_LOOKUP) state_q <= S_ALLOC;
      else if (state_q == S_ALLOC) begin
        state_q <= S_IDLE;
        if (on_q) begin
          period_q[sel] <= period;
          duty_q[sel] <= duty_on;
          note_q[sel] <= ev_note_q;
          active_q[sel] <= 1'b1;
          restart_q[sel] <= 1'b1;
          for (int i = 0; i < NUM_VOICES; i++)
            age_q[i] <= AW'(i) == sel ? 3'd0 :
                        (active_q[i] && age_q[i] != AGE_MAX) ? age_q[i] + 3'd1 : age_q[i];
        end else if (hit) begin
          duty_q[hit_idx] <= '0;
          active_q[hit_idx] <= 1'b0;
          age_q[hit_idx] <= '0;
        end
      end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scoreboard bench for voice_allocator
module tb_voice_allocator;
  typedef struct packed {
    logic [127:0] period;
    logic [127:0] duty;
    logic [27:0]  note;
    logic [3:0]   active;
    logic [3:0]   restart;
    logic [11:0]  age;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [31:0] m_per[4];
  logic [31:0] m_duty[4];
  logic [6:0] m_note[4];
  logic m_act[4];
  int m_age[4];
  int base_t[12] = '{5972, 5637, 5321, 5022, 4740, 4474, 4223, 3986, 3762, 3551, 3352, 3164};
  logic [3:0] last_restart;
  voice_allocator_if #(.NUM_VOICES(4), .PW(32)) bus ();
  voice_allocator #(.NUM_VOICES(4), .PW(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] period_of(input logic [6:0] note);
    int n;
    n = int'(note);
    return 32'(base_t[n % 12] << (10 - n / 12));
  endfunction
  function automatic logic [31:0] duty_of(input logic [31:0] p, input logic [1:0] dm);
    return dm == 2'd1 ? p >> 2 : dm == 2'd2 ? p >> 3 : dm == 2'd3 ? p - (p >> 2) : p >> 1;
  endfunction
  function automatic int pick(input logic [6:0] note);
    int best;
    for (int i = 0; i < 4; i++) if (m_act[i] && m_note[i] == note) return i;
    for (int i = 0; i < 4; i++) if (!m_act[i]) return i;
    best = 0;
    for (int i = 1; i < 4; i++) if (m_age[i] > m_age[best]) best = i;
    return best;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_per[i] = '0;
      m_duty[i] = '0;
      m_note[i] = '0;
      m_act[i] = 1'b0;
      m_age[i] = 0;
    end
  endtask
  function automatic exp_t snap(input logic [3:0] rs);
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.period[i*32 +: 32] = m_per[i];
      e.duty[i*32 +: 32] = m_duty[i];
      e.note[i*7 +: 7] = m_note[i];
      e.active[i] = m_act[i];
      e.age[i*3 +: 3] = 3'(m_age[i]);
    end
    e.restart = rs;
    return e;
  endfunction
  task automatic check_state(input string tag, input exp_t e);
    chk({tag, "_period"}, 128'(bus.voice_period), e.period);
    chk({tag, "_duty"}, 128'(bus.voice_duty), e.duty);
    chk({tag, "_note"}, 128'(bus.voice_note), 128'(e.note));
    chk({tag, "_active"}, 128'(bus.voice_active), 128'(e.active));
    chk({tag, "_restart"}, 128'(bus.voice_restart), 128'(e.restart));
    chk({tag, "_age"}, 128'(dut.age_q), 128'(e.age));
  endtask
  task automatic send(input string tag, input logic on, input logic [6:0] note, input logic [1:0] dm);
    exp_t e;
    logic [3:0] rs;
    int v;
    rs = '0;
    if (on) begin
      v = pick(note);
      for (int i = 0; i < 4; i++) if (i != v && m_act[i] && m_age[i] < 3) m_age[i]++;
      m_per[v] = period_of(note);
      m_duty[v] = duty_of(m_per[v], dm);
      m_note[v] = note;
      m_act[v] = 1'b1;
      m_age[v] = 0;
      rs[v] = 1'b1;
    end else
      for (int i = 0; i < 4; i++)
        if (m_act[i] && m_note[i] == note) begin
          m_duty[i] = '0;
          m_act[i] = 1'b0;
          m_age[i] = 0;
        end
    sb.push_back(snap(rs));
    @(negedge clk);
    chk({tag, "_ready_idle"}, 128'(bus.ev_ready), 128'(1));
    bus.ev_valid = 1'b1;
    bus.ev_on = on;
    bus.ev_note = note;
    bus.duty_mode = dm;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    chk({tag, "_ready_lookup"}, 128'(bus.ev_ready), 128'(0));
    @(negedge clk);
    chk({tag, "_ready_alloc"}, 128'(bus.ev_ready), 128'(0));
    @(negedge clk);
    chk({tag, "_ready_back"}, 128'(bus.ev_ready), 128'(1));
    last_restart = bus.voice_restart;
    e = sb.pop_front();
    check_state(tag, e);
    @(negedge clk);
    chk({tag, "_restart_clear"}, 128'(bus.voice_restart), 128'(0));
  endtask
  initial begin
    bus.ev_valid = 1'b0;
    bus.ev_on = 1'b0;
    bus.ev_note = '0;
    bus.duty_mode = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(bus.ev_ready), 128'(1));
    check_state("rst", snap(4'b0));
    send("on69", 1'b1, 7'd69, 2'd0);
    chk("on69_v0_period", 128'(bus.voice_period[31:0]), 128'd113632);
    chk("on69_v0_duty", 128'(bus.voice_duty[31:0]), 128'd56816);
    chk("on69_restart", 128'(last_restart), 128'(4'b0001));
    send("on60", 1'b1, 7'd60, 2'd1);
    send("on64", 1'b1, 7'd64, 2'd1);
    send("on67", 1'b1, 7'd67, 2'd1);
    chk("on60_v1_period", 128'(bus.voice_period[63:32]), 128'd191104);
    chk("on60_v1_duty", 128'(bus.voice_duty[63:32]), 128'd47776);
    chk("ages_full", 128'(dut.age_q), 128'(12'b000_001_010_011));
    send("steal72", 1'b1, 7'd72, 2'd1);
    chk("steal_v0_note", 128'(bus.voice_note[6:0]), 128'd72);
    chk("steal_v0_period", 128'(bus.voice_period[31:0]), 128'd95552);
    chk("steal_ages", 128'(dut.age_q), 128'(12'b001_010_011_000));
    send("retrig64", 1'b1, 7'd64, 2'd1);
    chk("retrig_restart", 128'(last_restart), 128'(4'b0100));
    chk("retrig_age2", 128'(dut.age_q[2]), 128'd0);
    send("off60", 1'b0, 7'd60, 2'd0);
    chk("off60_v1_duty", 128'(bus.voice_duty[63:32]), 128'd0);
    chk("off60_v1_period", 128'(bus.voice_period[63:32]), 128'd191104);
    chk("off60_v1_active", 128'(bus.voice_active[1]), 128'd0);
    send("off100", 1'b0, 7'd100, 2'd0);
    @(negedge clk);
    bus.ev_valid = 1'b1;
    bus.ev_on = 1'b1;
    bus.ev_note = 7'd50;
    bus.duty_mode = 2'd0;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    chk("abort_ready_lookup", 128'(bus.ev_ready), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_ready", 128'(bus.ev_ready), 128'(1));
    check_state("abort", snap(4'b0));
    send("on0", 1'b1, 7'd0, 2'd0);
    chk("on0_period", 128'(bus.voice_period[31:0]), 128'd6115328);
    send("on127", 1'b1, 7'd127, 2'd3);
    chk("on127_period", 128'(bus.voice_period[63:32]), 128'd3986);
    chk("on127_duty", 128'(bus.voice_duty[63:32]), 128'd2990);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller for the synth's bank of square-wave voice generators.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voices; steals the oldest voice when all are busy.
- Drives each voice's period, duty cycle and a phase-restart pulse, which feed the per-voice generator's period, duty_cycle and reset inputs.

Parameters:
- NUM_VOICES, 4, number of voices managed (2..8).
- PW, 32, width of the period and duty words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number, 0..127.
- duty_mode  in  2  duty select, sampled in ALLOC: 0 = 50%, 1 = 25%, 2 = 12.5%, 3 = 75%.
- voice_period  out  NUM_VOICES*PW  per-voice period in clk cycles; voice i at [i*PW +: PW].
- voice_duty  out  NUM_VOICES*PW  per-voice high time in clk cycles.
- voice_restart  out  NUM_VOICES  one-cycle pulse per voice to restart the generator phase.
- voice_active  out  NUM_VOICES  voice currently holds a sounding note.
- voice_note  out  NUM_VOICES*7  note held by each voice.

Behaviour:
- Reset: all outputs 0, all ages 0, FSM in IDLE; ev_ready = 1 once reset deasserts.
- Reset asserted mid-event aborts the event with no partial update.
- FSM states: IDLE -> LOOKUP -> ALLOC -> IDLE.
- IDLE:
  - ev_ready = 1.
  - On ev_valid && ev_ready at edge E0, latch ev_on and ev_note, then go to LOOKUP.
  - ev_ready = 0 in LOOKUP and ALLOC.
- LOOKUP: note_period_rom output is registered at E1.
  - Period = BASE[note % 12] << (10 - note / 12).
- ALLOC: voice registers update at E2; back to IDLE.
  - Throughput: one event per 3 cycles.
- Note-on voice selection, in priority order:
  1. An active voice with the same note (retrigger).
  2. The lowest-index inactive voice.
  3. The active voice with the largest age, lowest index on a tie (steal).
- Note-on update of the chosen voice v:
  - voice_period[v] = period.
  - voice_duty[v] = period>>1, period>>2, period>>3, or period - (period>>2) for duty_mode 0/1/2/3.
  - voice_note[v] = note, voice_active[v] = 1, voice_restart[v] pulses for the single cycle after E2.
- Age rule on note-on:
  - age[v] = 0.
  - Every other active voice's age increments, saturating at NUM_VOICES-1.
  - Inactive voices keep age 0.
- Note-off:
  - On the active voice with a matching note: voice_duty = 0, voice_period unchanged (so the generator output goes low), voice_active = 0, age = 0.
  - No restart pulse.
  - No match: event is consumed with no state change.
- No two active voices ever hold the same note.
- Arithmetic: all shifts use PW-bit unsigned values; maximum period (note 0) = 5972<<10 = 6115328, which fits in 32 bits.
- voice_restart is otherwise 0.

Decomposition:
- Package synth_pkg:
  - The 12 BASE constants for a 50 MHz clk (top octave, notes 120..131): 5972, 5637, 5321, 5022, 4740, 4474, 4223, 3986, 3762, 3551, 3352, 3164.
  - FSM state encoding.
  - Duty-mode encoding.
- Sub-module note_period_rom: 7-bit note in, registered PW-bit period out, 1-cycle latency.

Test Plan:
- Reset, then note-on 69 with duty_mode 0:
  - Voice 0 gets period 113632, duty 56816, active = 1.
  - restart[0] pulses for one cycle.
  - ev_ready low for exactly 2 cycles after acceptance.
- Note-on 60, 64, 67 with duty_mode 1:
  - Voices 1, 2, 3 are assigned; voice 1 period 5972<<5 = 191104, duty 47776.
  - Ages after the last event: v0 = 3, v1 = 2, v2 = 1, v3 = 0.
- Fifth note-on 72 with all voices busy:
  - Voice 0 is stolen, note 72, period 95552.
  - Ages: v0 = 0, v1 = 3, v2 = 2, v3 = 1.
- Note-on 64 again: voice 2 retriggers, restart[2] pulses, no other voice changes, age[2] = 0.
- Note-off 60:
  - Voice 1 duty = 0, period still 191104, active = 0.
  - Note-off 100 (unmatched) changes nothing and ev_ready returns high.
- Event accepted, then reset asserted during LOOKUP: all outputs 0 and ev_ready = 1 after release; note 0 then yields period 6115328, and note 127 with duty_mode 3 yields period 3986, duty 2990.
